aoi22_toggle_seq: RTL and testbench
===================================

# aoi22_toggle_seq

Synchronous stimulus sequencer and checker sitting directly upstream of an AOI22X1 cell in the power-characterization bench. It drives the cell's four inputs through all 256 ordered (from, to) input-vector pairs. After each vector it samples the cell's QN, checks it against the AOI22 function, and counts QN toggles and mismatches. Results feed the switching-activity and power-annotation flow.

## Interface
- SETTLE, default 2: cycles each vector is held before QN is sampled; legal range 1..15.
- CLK  input  1  rising-edge clock.
- RSTB  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- START  input  1  run request; sampled only in IDLE.
- QN_IN  input  1  QN of the driven AOI22X1.
- OUT1, OUT2, OUT3, OUT4  output  1 each  drive IN1..IN4 of the cell.
- BUSY  output  1  high while a run is in progress.
- DONE  output  1  one-cycle pulse when a run completes.
- TOGGLES  output  8  count of pairs where sampled QN differed between from and to; saturates at 255.
- ERRS  output  10  count of QN samples not matching the expected value; saturates at 1023.

## Operation
- Pair index P runs 0..255. from = P[7:4], to = P[3:0].
- Vector bit mapping: OUT1 = v[3], OUT2 = v[2], OUT3 = v[1], OUT4 = v[0].
- Expected QN = ~((v[3]&v[2]) | (v[1]&v[0])).
- States: IDLE, FROM, TO, FIN.
- IDLE: OUT* = 0, BUSY = 0. On START = 1: clear TOGGLES/ERRS, set P = 0, drive from(0), load settle counter with SETTLE, go to FROM.
- FROM: the counter decrements each cycle. On the SETTLE-th edge:
  - capture QN_IN into qn_from;
  - ERRS += 1 if qn_from differs from the expected value;
  - drive to(P), reload the counter, go to TO.
- TO: on the SETTLE-th edge:
  - compare QN_IN against the expected value and update ERRS;
  - TOGGLES += 1 if QN_IN != qn_from;
  - if P == 255, go to FIN and drive OUT* = 0;
  - otherwise P += 1, drive from(P), go to FROM.
- FIN: DONE = 1 for one cycle, BUSY = 0, then IDLE.
- Counters hold their final values until the next accepted START.
- Both counters saturate and never wrap.
- START while in FROM, TO or FIN is ignored, whether level-held or pulsed.
- RSTB assertion at any time:
  - all state and outputs go to reset values immediately;
  - the run is abandoned, with no DONE.

## Timing
- Reset values: OUT1..OUT4 = 0, BUSY = 0, DONE = 0, TOGGLES = 0, ERRS = 0, state = IDLE.
- All outputs are registered. QN_IN is sampled only on the counter-terminal edge.
- Start cycle: START is seen at edge k. After edge k, BUSY = 1 and OUT* = 0000.
- First sample is at edge k+SETTLE. Final sample is at edge k+512·SETTLE.
- After the final-sample edge:
  - BUSY = 0, DONE = 1, and both counters are final;
  - DONE drops after the next edge.
- A new START is accepted no earlier than the edge after DONE.
- The same edge that applies a vector also reloads the counter. Every vector is therefore stable for exactly SETTLE cycles before it is sampled.

## Structure
- Package aoi22_seq_pkg holds:
  - the state enum;
  - P_W = 8, TOG_W = 8, ERR_W = 10;
  - function aoi22_ref(v[3:0]) returning the expected QN.
- The bench checker reuses aoi22_ref.
- One sub-module, sat_cnt #(W), is instantiated twice. It is an incrementing counter with synchronous clear and saturation, and async active-low reset.

## Test plan
- SETTLE = 2, a real AOI22X1 on OUT*/QN_IN, one START pulse:
  - DONE 1024 cycles after the start edge;
  - ERRS = 0, TOGGLES = 126.
- QN_IN tied to 1:
  - ERRS = 224 (7 zero-expected vectors × 16 × 2);
  - TOGGLES = 0.
- QN_IN = inverted AOI22 output:
  - ERRS = 512, TOGGLES = 126.
- SETTLE = 1:
  - OUT sequence starts 0000, 0000, 0000, 0001, 0000, 0010;
  - DONE after 512 cycles.
- START held high through the run plus extra pulses mid-run:
  - exactly one run occurs and one DONE pulse;
  - a START after DONE clears the counters on the accept edge and reruns to the same results.
- RSTB low during pair 100:
  - OUT*, BUSY, DONE and the counters are 0 immediately, with no DONE pulse;
  - after release, a new START completes with ERRS = 0, TOGGLES = 126.

Source files
------------

// File: rtl/aoi22_seq_pkg.sv
// Shared types, widths and the AOI22 reference function for the toggle sequencer.
package aoi22_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FROM = 2'd1,
    ST_TO   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam int P_W   = 8;
  localparam int TOG_W = 8;
  localparam int ERR_W = 10;

  // Expected QN of an AOI22X1 for inputs {IN1, IN2, IN3, IN4} = v[3:0].
  function automatic logic aoi22_ref(input logic [3:0] v);
    return ~((v[3] & v[2]) | (v[1] & v[0]));
  endfunction

endpackage

// File: rtl/aoi22_toggle_seq_if.sv
// Bundle between the sequencer (master) and the cell/bench environment (slave).
interface aoi22_toggle_seq_if;
  import aoi22_seq_pkg::*;

  logic             START;
  logic             QN_IN;
  logic             OUT1;
  logic             OUT2;
  logic             OUT3;
  logic             OUT4;
  logic             BUSY;
  logic             DONE;
  logic [TOG_W-1:0] TOGGLES;
  logic [ERR_W-1:0] ERRS;

  modport master (
    input  START, QN_IN,
    output OUT1, OUT2, OUT3, OUT4, BUSY, DONE, TOGGLES, ERRS
  );

  modport slave (
    output START, QN_IN,
    input  OUT1, OUT2, OUT3, OUT4, BUSY, DONE, TOGGLES, ERRS
  );

endinterface

// File: rtl/aoi22_toggle_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count register: clear wins over increment, increment stops at the maximum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/aoi22_toggle_seq.sv
// Walks an AOI22X1 through all 256 (from, to) input pairs, checking QN and
// counting QN toggles and mismatches.
module aoi22_toggle_seq
  import aoi22_seq_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic              CLK,
  input  logic              RSTB,
  aoi22_toggle_seq_if.master bus
);

  localparam logic [3:0] L_SETTLE = 4'(SETTLE);

  state_t           r_state;
  logic [P_W-1:0]   r_p;
  logic [3:0]       r_cnt;
  logic [3:0]       r_vec;
  logic             r_qn_from;
  logic             r_busy;
  logic             r_done;

  logic             w_term;
  logic             w_clr;
  logic             w_err_inc;
  logic             w_tog_inc;
  logic [P_W-1:0]   w_p_nxt;
  logic [TOG_W-1:0] w_toggles;
  logic [ERR_W-1:0] w_errs;

  assign w_term  = (r_cnt == 4'd1);
  assign w_p_nxt = r_p + 8'd1;

  // Counter strobes, only on the settle-terminal edge of a vector.
  always_comb begin
    w_clr     = (r_state == ST_IDLE) && bus.START;
    w_err_inc = 1'b0;
    w_tog_inc = 1'b0;
    case (r_state)
      ST_FROM: begin
        if (w_term) begin
          w_err_inc = (bus.QN_IN != aoi22_ref(r_p[7:4]));
        end else begin
          w_err_inc = 1'b0;
        end
      end
      ST_TO: begin
        if (w_term) begin
          w_err_inc = (bus.QN_IN != aoi22_ref(r_p[3:0]));
          w_tog_inc = (bus.QN_IN != r_qn_from);
        end else begin
          w_err_inc = 1'b0;
          w_tog_inc = 1'b0;
        end
      end
      default: begin
        w_err_inc = 1'b0;
        w_tog_inc = 1'b0;
      end
    endcase
  end

  // Sequencer FSM; the edge that applies a vector also reloads the settle counter.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state   <= ST_IDLE;
      r_p       <= {P_W{1'b0}};
      r_cnt     <= 4'd0;
      r_vec     <= 4'd0;
      r_qn_from <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_vec  <= 4'd0;
          if (bus.START) begin
            r_state <= ST_FROM;
            r_busy  <= 1'b1;
            r_p     <= {P_W{1'b0}};
            r_cnt   <= L_SETTLE;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_FROM: begin
          if (w_term) begin
            r_qn_from <= bus.QN_IN;
            r_vec     <= r_p[3:0];
            r_cnt     <= L_SETTLE;
            r_state   <= ST_TO;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_TO: begin
          if (w_term && (r_p == 8'd255)) begin
            r_vec   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else if (w_term) begin
            r_p     <= w_p_nxt;
            r_vec   <= w_p_nxt[7:4];
            r_cnt   <= L_SETTLE;
            r_state <= ST_FROM;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_vec   <= 4'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  sat_cnt #(.W(TOG_W)) u_tog_cnt (
    .i_clk   (CLK),
    .i_rst_n (RSTB),
    .i_clr   (w_clr),
    .i_inc   (w_tog_inc),
    .o_cnt   (w_toggles)
  );

  sat_cnt #(.W(ERR_W)) u_err_cnt (
    .i_clk   (CLK),
    .i_rst_n (RSTB),
    .i_clr   (w_clr),
    .i_inc   (w_err_inc),
    .o_cnt   (w_errs)
  );

  assign bus.OUT1    = r_vec[3];
  assign bus.OUT2    = r_vec[2];
  assign bus.OUT3    = r_vec[1];
  assign bus.OUT4    = r_vec[0];
  assign bus.BUSY    = r_busy;
  assign bus.DONE    = r_done;
  assign bus.TOGGLES = w_toggles;
  assign bus.ERRS    = w_errs;

endmodule

// File: tb/tb_aoi22_toggle_seq.sv
// Bench for aoi22_toggle_seq: SETTLE=2 and SETTLE=1 instances, table-driven runs
// against a cycle-indexed reference model of the pair walk.
module tb_aoi22_toggle_seq;
  import aoi22_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2_n;
  logic rst1_n;
  int   mode2;
  logic qv2;

  aoi22_toggle_seq_if if2 ();
  aoi22_toggle_seq_if if1 ();

  aoi22_toggle_seq #(.SETTLE(2)) u_s2 (.CLK(clk), .RSTB(rst2_n), .bus(if2.master));
  aoi22_toggle_seq #(.SETTLE(1)) u_s1 (.CLK(clk), .RSTB(rst1_n), .bus(if1.master));

  // Behavioural AOI22X1 cells hanging off each sequencer.
  wire cell2 = ~((if2.OUT1 & if2.OUT2) | (if2.OUT3 & if2.OUT4));
  wire cell1 = ~((if1.OUT1 & if1.OUT2) | (if1.OUT3 & if1.OUT4));

  assign if2.QN_IN = (mode2 == 0) ? cell2 : (mode2 == 2) ? ~cell2 : qv2;
  assign if1.QN_IN = cell1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Vector on OUT* after start-edge + n cycles: sample m = n/s is being settled.
  function automatic logic [3:0] exp_vec(input int n, input int s);
    int m, p;
    m = n / s;
    if (m >= 512) return 4'd0;
    p = m / 2;
    if (m % 2 == 0) return 4'((p >> 4) & 15);
    return 4'(p & 15);
  endfunction

  // mode: 0 cell, 1 tied high, 2 inverted cell, 3 random, 4 alternating per sample.
  // sctl: 0 single pulse, 1 held through run, 2 random START during run.
  task automatic run_s2(input int mode, input int sctl, input int abort_n,
                        output int e_errs, output int e_togs);
    localparam int S = 2;
    int         total;
    logic       lg[$];
    int         bad;
    int         dones;
    logic [3:0] o;
    logic       q, qf;
    total  = 512 * S;
    bad    = 0;
    dones  = 0;
    e_errs = 0;
    e_togs = 0;
    mode2  = mode;
    @(posedge clk); #1;
    if2.START = 1'b1;
    for (int n = 0; n <= total + 3; n++) begin
      @(posedge clk); #1;
      if (n >= total)     if2.START = 1'b0;
      else if (sctl == 0) if2.START = 1'b0;
      else if (sctl == 1) if2.START = 1'b1;
      else                if2.START = 1'($urandom_range(0, 1));
      qv2 = (mode == 1) ? 1'b1 : (mode == 4) ? 1'(((n + 1) / S) % 2) :
            (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      lg.push_back(if2.QN_IN);
      o = {if2.OUT1, if2.OUT2, if2.OUT3, if2.OUT4};
      if (o !== exp_vec(n, S) || if2.BUSY !== (n < total) || if2.DONE !== (n == total)) bad++;
      if (if2.DONE === 1'b1) dones++;
      if (n == 0) begin
        chk("accept_clear_errs", 32'(if2.ERRS), 32'd0);
        chk("accept_clear_togs", 32'(if2.TOGGLES), 32'd0);
      end
      if (n == abort_n) begin
        chk("pre_abort_trace", 32'(bad), 32'd0);
        chk("pre_abort_errs_nonzero", 32'(if2.ERRS != 10'd0), 32'd1);
        if2.START = 1'b0;
        rst2_n = 1'b0;
        #1;
        chk("rst_out", 32'({if2.OUT1, if2.OUT2, if2.OUT3, if2.OUT4}), 32'd0);
        chk("rst_busy", 32'(if2.BUSY), 32'd0);
        chk("rst_done", 32'(if2.DONE), 32'd0);
        chk("rst_errs", 32'(if2.ERRS), 32'd0);
        chk("rst_togs", 32'(if2.TOGGLES), 32'd0);
        bad = 0;
        repeat (3) begin
          @(negedge clk);
          if (if2.DONE !== 1'b0 || if2.BUSY !== 1'b0) bad++;
        end
        rst2_n = 1'b1;
        repeat (2) @(negedge clk);
        if (if2.DONE !== 1'b0 || if2.BUSY !== 1'b0) bad++;
        chk("rst_no_done", 32'(bad), 32'd0);
        return;
      end
    end
    // Reference: sample m lands on start-edge + (m+1)*S, i.e. log index (m+1)*S-1.
    for (int m = 0; m < 512; m++) begin
      q = lg[(m + 1) * S - 1];
      if (q !== aoi22_ref(exp_vec(m * S, S))) e_errs++;
      if (m % 2 == 1) begin
        qf = lg[m * S - 1];
        if (q !== qf) e_togs++;
      end
    end
    if (e_errs > 1023) e_errs = 1023;
    if (e_togs > 255)  e_togs = 255;
    chk("trace", 32'(bad), 32'd0);
    chk("done_pulses", 32'(dones), 32'd1);
    chk("errs_vs_model", 32'(if2.ERRS), 32'(e_errs));
    chk("togs_vs_model", 32'(if2.TOGGLES), 32'(e_togs));
  endtask

  typedef struct {
    int    mode;
    int    sctl;
    int    errs;
    int    togs;
    string nm;
  } run_t;

  typedef struct {
    logic [3:0] out;
    logic       busy;
  } ov_t;

  run_t runs[7];
  ov_t  seq1[6];

  initial begin
    int         ee, et, done_n;
    logic [3:0] o;

    runs[0] = '{0, 0, 0,   126, "cell"};
    runs[1] = '{1, 0, 224, 0,   "tied1"};
    runs[2] = '{2, 0, 512, 126, "inverted"};
    runs[3] = '{4, 0, 256, 255, "alt_saturate"};
    runs[4] = '{1, 1, 224, 0,   "start_held"};
    runs[5] = '{1, 0, 224, 0,   "rerun"};
    runs[6] = '{1, 2, 224, 0,   "start_noise"};
    seq1[0] = '{4'b0000, 1'b1};
    seq1[1] = '{4'b0000, 1'b1};
    seq1[2] = '{4'b0000, 1'b1};
    seq1[3] = '{4'b0001, 1'b1};
    seq1[4] = '{4'b0000, 1'b1};
    seq1[5] = '{4'b0010, 1'b1};

    rst2_n = 1'b0;
    rst1_n = 1'b0;
    mode2  = 0;
    qv2    = 1'b0;
    if2.START = 1'b0;
    if1.START = 1'b0;
    #1;
    chk("reset_out", 32'({if2.OUT1, if2.OUT2, if2.OUT3, if2.OUT4}), 32'd0);
    chk("reset_busy", 32'(if2.BUSY), 32'd0);
    chk("reset_done", 32'(if2.DONE), 32'd0);
    chk("reset_errs", 32'(if2.ERRS), 32'd0);
    chk("reset_togs", 32'(if2.TOGGLES), 32'd0);
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    rst1_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(if2.BUSY), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_s2(runs[i].mode, runs[i].sctl, -1, ee, et);
      chk($sformatf("%s_errs", runs[i].nm), 32'(if2.ERRS), 32'(runs[i].errs));
      chk($sformatf("%s_togs", runs[i].nm), 32'(if2.TOGGLES), 32'(runs[i].togs));
    end

    run_s2(3, 2, -1, ee, et);

    // Abort during pair 100 (from phase), then a clean run.
    run_s2(1, 0, 2 * 100 * 2 + 1, ee, et);
    run_s2(0, 0, -1, ee, et);
    chk("after_rst_errs", 32'(if2.ERRS), 32'd0);
    chk("after_rst_togs", 32'(if2.TOGGLES), 32'd126);

    // SETTLE = 1 instance.
    done_n = -1;
    @(posedge clk); #1;
    if1.START = 1'b1;
    for (int n = 0; n <= 515; n++) begin
      @(posedge clk); #1;
      if1.START = 1'b0;
      @(negedge clk);
      o = {if1.OUT1, if1.OUT2, if1.OUT3, if1.OUT4};
      if (n < 6) begin
        chk($sformatf("s1_out_%0d", n), 32'(o), 32'(seq1[n].out));
        chk($sformatf("s1_busy_%0d", n), 32'(if1.BUSY), 32'(seq1[n].busy));
      end
      if (if1.DONE === 1'b1 && done_n < 0) done_n = n;
    end
    chk("s1_done_cycle", 32'(done_n), 32'd512);
    chk("s1_errs", 32'(if1.ERRS), 32'd0);
    chk("s1_togs", 32'(if1.TOGGLES), 32'd126);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
